// File: rtl/register_dump_unit.sv
// register_dump_unit: walks every GPR through the debug read port and streams each value out as little-endian bytes
module register_dump_unit #(
    parameter int NB   = 32,
    parameter int REGS = 5,
    parameter int BYTE = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    output logic [REGS-1:0] o_mips_register_number,
    input  logic [NB-1:0]   i_reg_data,
    output logic [BYTE-1:0] o_tx_data,
    output logic            o_tx_valid,
    input  logic            i_tx_ready,
    output logic            o_busy,
    output logic            o_done
);
    localparam int BPW = NB / BYTE;
    localparam int CW  = $clog2(BPW + 1);
    typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SEND, DONE} state_t;
    state_t          state_q;
    logic [REGS-1:0] idx_q;
    logic [CW-1:0]   byte_cnt_q;
    logic [NB-1:0]   word_q;
    logic [NB-1:0]   word_d;
    logic [BYTE-1:0] tx_data_q;
    logic            tx_valid_q;
    logic            busy_q;
    logic            done_q;
    // word after the current low byte has been handed to TX
    always_comb word_d = word_q >> BYTE;
    // dump sequencer; every output is a register so valid never depends on ready
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    state_q <= WAIT;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
                WAIT: state_q <= CAPTURE;
                CAPTURE: begin
                    word_q     <= i_reg_data;
                    byte_cnt_q <= '0;
                    tx_data_q  <= i_reg_data[BYTE-1:0];
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: if (tx_valid_q && i_tx_ready) begin
                    word_q     <= word_d;
                    tx_data_q  <= word_d[BYTE-1:0];
                    byte_cnt_q <= byte_cnt_q + CW'(1);
                    if (byte_cnt_q == CW'(BPW - 1)) begin
                        tx_valid_q <= 1'b0;
                        if (idx_q == {REGS{1'b1}}) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + REGS'(1);
                            state_q <= WAIT;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign o_mips_register_number = idx_q;
    assign o_tx_data              = tx_data_q;
    assign o_tx_valid             = tx_valid_q;
    assign o_busy                 = busy_q;
    assign o_done                 = done_q;
endmodule

// File: tb/tb_register_dump_unit.sv
// tb_register_dump_unit: scoreboard bench with a 1-cycle-latency register file model
module tb_register_dump_unit;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  o_mips_register_number;
    logic [31:0] i_reg_data = '0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_done;

    register_dump_unit dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .o_mips_register_number(o_mips_register_number), .i_reg_data(i_reg_data),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {logic [7:0] b; logic [4:0] r;} exp_t;
    exp_t        exp_q[$];
    logic [31:0] rf[32];
    int checks = 0, passed = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, first_v = -1;
    int nbytes = 0, stalls = 0, done_cnt = 0, rmode = 0;
    logic busy_at_done = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(posedge i_clk) i_reg_data <= rf[o_mips_register_number];
    always @(posedge i_clk) begin
        #1;
        i_tx_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // monitor: pops the scoreboard on every accepted byte and checks hold-while-stalled
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(o_tx_valid), 32'd1);
                chk("hold_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (o_tx_valid && first_v < 0) first_v = cyc;
            if (o_tx_valid && i_tx_ready) begin
                if (exp_q.size() == 0) chk("unexpected_byte_qsize", exp_q.size(), 32'd1);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d_data", nbytes), 32'(o_tx_data), 32'(e.b));
                    chk($sformatf("byte%0d_regnum", nbytes), 32'(o_mips_register_number), 32'(e.r));
                end
                nbytes++;
            end
            if (o_tx_valid && !i_tx_ready) stalls++;
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data = o_tx_data;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = o_busy;
            end
        end else prev_stall = 1'b0;
    end

    task automatic fill_rf(input bit rnd);
        for (int k = 0; k < 32; k++) rf[k] = rnd ? $urandom : 32'hA500_0000 + k;
    endtask

    task automatic start_dump(input int mode);
        exp_q.delete();
        for (int k = 0; k < 32; k++)
            for (int b = 0; b < 4; b++) exp_q.push_back('{b: rf[k][8*b +: 8], r: 5'(k)});
        nbytes = 0; stalls = 0; done_cnt = 0; first_v = -1;
        @(negedge i_clk);
        rmode = mode;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        start_cyc = cyc;
        i_start = 1'b0;
    endtask

    task automatic finish_dump(input int busy_at);
        bit pulsed = 0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(negedge i_clk);
            if (busy_at > 0 && nbytes >= busy_at && !pulsed) begin
                i_start = 1'b1;
                pulsed = 1;
            end else i_start = 1'b0;
        end
        i_start = 1'b0;
        chk("done_seen", done_cnt, 32'd1);
        chk("done_cycle", done_cyc - start_cyc + 1, 193 + stalls);
        chk("busy_during_done", 32'(busy_at_done), 32'd1);
        chk("first_valid_latency", first_v - start_cyc, 32'd2);
        @(negedge i_clk);
        chk("busy_after_done", 32'(o_busy), 32'd0);
        repeat (5) @(negedge i_clk);
        chk("single_done", done_cnt, 32'd1);
        chk("byte_total", nbytes, 32'd128);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        fill_rf(0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_regnum", 32'(o_mips_register_number), 32'd0);
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        start_dump(0);
        finish_dump(0);
        start_dump(1);
        finish_dump(0);
        fill_rf(1);
        start_dump(1);
        finish_dump(0);
        fill_rf(1);
        start_dump(0);
        finish_dump(10);
        fill_rf(1);
        start_dump(0);
        for (int i = 0; i < 500 && !(nbytes == 30 && o_tx_valid); i++) begin
            @(posedge i_clk);
            #2;
        end
        chk("abort_point_bytes", nbytes, 32'd30);
        chk("abort_point_regnum", 32'(o_mips_register_number), 32'd7);
        rmode = 2;
        i_tx_ready = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("abort_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_regnum", 32'(o_mips_register_number), 32'd0);
        chk("abort_tx_data", 32'(o_tx_data), 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("abort_no_done", done_cnt, 32'd0);
        fill_rf(0);
        start_dump(1);
        finish_dump(0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
